multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle control FSM driving the 8-bit accumulator DataPath (13-bit address space).
//  Decodes the opcode nibble (toCU), sequences fetch/decode/execute, and drives every DataPath enable/select.
//  Keeps its own C/Z/N shadow flags for conditional branches.
// PARAMETERS
//  ADD_OP  3'b000  ALU func code driven on `operation` for memory-operand add (ADDM)
// PORTS
//  clk  in  1  system clock, rising edge
//  reset  in  1  synchronous, active-high
//  toCU  in  4  memory word [7:4] (combinational from memory read)
//  jmpCond  in  2  DI[2:1] branch condition
//  CC, ZZ, NN  in  1 each  ALU carry/zero/negative (combinational)
//  pcEn, selPC, selAddress, mr, mw  out  1 each  PC/memory control
//  wordRegEn, LSEn, RSEn, DIEn, dataRegEn, resultRegEn  out  1 each  register enables
//  CEn, ZEn, NEn  out  1 each  flag register enables
//  selALUsrc, enb  out  1 each  ALU B source (0 dataReg, 1 memory word) / accumulator write
//  selData  out  2  AC write data: 0 memory word, 1 resultReg, 2 dataReg
//  selAddressAC  out  2  AC index: 0 DI[4:3], 1 LS[1:0], 2 LS[3:2]
//  operation  out  3  ALU function
//  halted  out  1  high in HALT state
// BEHAVIOUR
//  - Reset: state<=FETCH1, opcode_q<=0, flags C/Z/N<=0. While reset high, all outputs forced 0.
//  - Outputs are Moore-decoded from state, opcode_q, jmpCond, and flags. Every signal not listed for a state is 0.
//    selAddress=1 selects RI as the memory address; selPC=1 selects RI as the next PC.
//  - FETCH1: mr, LSEn, pcEn (selPC=0). Capture opcode_q<=toCU. Next: DECODE.
//  - DECODE (no outputs): opcode_q[3]=1 -> REG_A; opcode_q=0111 -> HALT; else -> FETCH2.
//  - FETCH2: mr, RSEn, DIEn, pcEn. Next state by opcode_q:
//    0000 LD; 0001 ST1; 0010 JMP; 0011 BR; 0100 ADDM1; 0101/0110 -> FETCH1 (NOP).
//  - LD: selAddress=1, mr, selData=0, selAddressAC=0, enb -> FETCH1.
//  - ST1: selAddressAC=0, dataRegEn -> ST2.
//  - ST2: selAddress=1, mw -> FETCH1.
//  - JMP: pcEn, selPC=1 -> FETCH1.
//  - BR: taken when jmpCond==00, or 01 and Z, or 10 and C, or 11 and N.
//    Taken: pcEn, selPC=1. Not taken: no outputs. Next: FETCH1.
//  - ADDM1: selAddress=1, mr, selAddressAC=0, selALUsrc=1, operation=ADD_OP, resultRegEn, CEn, ZEn, NEn -> ADDM2.
//  - ADDM2: selData=1, selAddressAC=0, enb -> FETCH1.
//  - REG_A: selAddressAC=2, dataRegEn -> REG_B.
//  - REG_B: selAddressAC=1, selALUsrc=0, operation=opcode_q[2:0], resultRegEn, CEn, ZEn, NEn -> REG_WB.
//  - REG_WB: selData=1, selAddressAC=1, enb -> FETCH1.
//  - Flags: on any edge where CEn/ZEn/NEn is asserted, C<=CC, Z<=ZZ, N<=NN.
//    Flags are unchanged otherwise; branches read only the registered flags.
//  - HALT: halted=1, all other outputs 0. Held until reset.
//  - Cycle counts (FETCH1 to next FETCH1):
//    LD 4, ST 5, JMP 4, BR 4, ADDM 5, reg-op 5, NOP 3.
//  - PC wrap 8191->0 is DataPath's job; the controller has no address awareness.
//  - Reset mid-instruction: the current cycle's outputs are 0 (no mw/enb side effect), then FETCH1.
//  - wordRegEn is always 0 (word register is bypassed).
// TESTING
//  1. Hold reset 3 cycles: all outputs 0. Release: first cycle FETCH1 with mr=LSEn=pcEn=1.
//  2. LD (toCU=0000 at FETCH1): DECODE, FETCH2 (RSEn=DIEn=pcEn=1), LD (enb=1, selData=0, selAddress=1); FETCH1 on cycle 5.
//  3. Reg op toCU=1010: REG_A dataRegEn/selAddressAC=2; REG_B operation=3'b010 with C/Z/N enables;
//     REG_WB enb, selData=1, selAddressAC=1.
//  4. ADDM with ZZ=1 in ADDM1, then BR jmpCond=01: BR asserts pcEn=selPC=1.
//     Repeat with ZZ=0: BR asserts no outputs.
//  5. toCU=0111: halted=1 and all other outputs 0 for 20 cycles. Reset: FETCH1 next cycle, halted=0.
//  6. Reset asserted in ST1 during a STORE: mw never asserts; next state FETCH1.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Fetch/decode/execute FSM driving the 8-bit accumulator DataPath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
   parameter logic [2:0] ADD_OP = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] toCU,
   input  logic [1:0] jmpCond,
   input  logic       CC,
   input  logic       ZZ,
   input  logic       NN,
   output logic       pcEn,
   output logic       selPC,
   output logic       selAddress,
   output logic       mr,
   output logic       mw,
   output logic       wordRegEn,
   output logic       LSEn,
   output logic       RSEn,
   output logic       DIEn,
   output logic       dataRegEn,
   output logic       resultRegEn,
   output logic       CEn,
   output logic       ZEn,
   output logic       NEn,
   output logic       selALUsrc,
   output logic       enb,
   output logic [1:0] selData,
   output logic [1:0] selAddressAC,
   output logic [2:0] operation,
   output logic       halted
);

   typedef enum logic [3:0] {
      S_FETCH1 = 4'd0,
      S_DECODE = 4'd1,
      S_FETCH2 = 4'd2,
      S_LD     = 4'd3,
      S_ST1    = 4'd4,
      S_ST2    = 4'd5,
      S_JMP    = 4'd6,
      S_BR     = 4'd7,
      S_ADDM1  = 4'd8,
      S_ADDM2  = 4'd9,
      S_REG_A  = 4'd10,
      S_REG_B  = 4'd11,
      S_REG_WB = 4'd12,
      S_HALT   = 4'd13
   } state_t;

   state_t     r_state;
   state_t     w_nextState;
   logic [3:0] r_opcode;
   logic       r_flagC;
   logic       r_flagZ;
   logic       r_flagN;
   logic       w_branchTaken;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FETCH1;
         r_opcode <= 4'd0;
         r_flagC  <= 1'b0;
         r_flagZ  <= 1'b0;
         r_flagN  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (r_state == S_FETCH1) r_opcode <= toCU;
         // Enables are already zero while reset is high, so no extra gating here.
         if (CEn) r_flagC <= CC;
         if (ZEn) r_flagZ <= ZZ;
         if (NEn) r_flagN <= NN;
      end
   end

   always_comb begin
      w_branchTaken = 1'b0;
      unique case (jmpCond)
         2'b00: w_branchTaken = 1'b1;
         2'b01: w_branchTaken = r_flagZ;
         2'b10: w_branchTaken = r_flagC;
         2'b11: w_branchTaken = r_flagN;
         default: w_branchTaken = 1'b0;
      endcase
   end

   always_comb begin
      w_nextState  = r_state;
      pcEn         = 1'b0;
      selPC        = 1'b0;
      selAddress   = 1'b0;
      mr           = 1'b0;
      mw           = 1'b0;
      wordRegEn    = 1'b0;
      LSEn         = 1'b0;
      RSEn         = 1'b0;
      DIEn         = 1'b0;
      dataRegEn    = 1'b0;
      resultRegEn  = 1'b0;
      CEn          = 1'b0;
      ZEn          = 1'b0;
      NEn          = 1'b0;
      selALUsrc    = 1'b0;
      enb          = 1'b0;
      selData      = 2'd0;
      selAddressAC = 2'd0;
      operation    = 3'd0;
      halted       = 1'b0;

      // Outputs stay quiet during reset so an interrupted store never writes.
      if (!reset) begin
         case (r_state)
            S_FETCH1: begin
               mr          = 1'b1;
               LSEn        = 1'b1;
               pcEn        = 1'b1;
               w_nextState = S_DECODE;
            end
            S_DECODE: begin
               if (r_opcode[3])               w_nextState = S_REG_A;
               else if (r_opcode == 4'b0111)  w_nextState = S_HALT;
               else                           w_nextState = S_FETCH2;
            end
            S_FETCH2: begin
               mr   = 1'b1;
               RSEn = 1'b1;
               DIEn = 1'b1;
               pcEn = 1'b1;
               case (r_opcode[2:0])
                  3'b000:  w_nextState = S_LD;
                  3'b001:  w_nextState = S_ST1;
                  3'b010:  w_nextState = S_JMP;
                  3'b011:  w_nextState = S_BR;
                  3'b100:  w_nextState = S_ADDM1;
                  default: w_nextState = S_FETCH1;
               endcase
            end
            S_LD: begin
               selAddress  = 1'b1;
               mr          = 1'b1;
               enb         = 1'b1;
               w_nextState = S_FETCH1;
            end
            S_ST1: begin
               dataRegEn   = 1'b1;
               w_nextState = S_ST2;
            end
            S_ST2: begin
               selAddress  = 1'b1;
               mw          = 1'b1;
               w_nextState = S_FETCH1;
            end
            S_JMP: begin
               pcEn        = 1'b1;
               selPC       = 1'b1;
               w_nextState = S_FETCH1;
            end
            S_BR: begin
               pcEn        = w_branchTaken;
               selPC       = w_branchTaken;
               w_nextState = S_FETCH1;
            end
            S_ADDM1: begin
               selAddress  = 1'b1;
               mr          = 1'b1;
               selALUsrc   = 1'b1;
               operation   = ADD_OP;
               resultRegEn = 1'b1;
               CEn         = 1'b1;
               ZEn         = 1'b1;
               NEn         = 1'b1;
               w_nextState = S_ADDM2;
            end
            S_ADDM2: begin
               selData     = 2'd1;
               enb         = 1'b1;
               w_nextState = S_FETCH1;
            end
            S_REG_A: begin
               selAddressAC = 2'd2;
               dataRegEn    = 1'b1;
               w_nextState  = S_REG_B;
            end
            S_REG_B: begin
               selAddressAC = 2'd1;
               operation    = r_opcode[2:0];
               resultRegEn  = 1'b1;
               CEn          = 1'b1;
               ZEn          = 1'b1;
               NEn          = 1'b1;
               w_nextState  = S_REG_WB;
            end
            S_REG_WB: begin
               selData      = 2'd1;
               selAddressAC = 2'd1;
               enb          = 1'b1;
               w_nextState  = S_FETCH1;
            end
            S_HALT: begin
               halted      = 1'b1;
               w_nextState = S_HALT;
            end
            default: w_nextState = S_FETCH1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Instruction-level reference model bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] toCU;
   logic [1:0] jmpCond;
   logic       CC, ZZ, NN;
   logic       pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn;
   logic       dataRegEn, resultRegEn, CEn, ZEn, NEn, selALUsrc, enb, halted;
   logic [1:0] selData, selAddressAC;
   logic [2:0] operation;

   always #5 clk = ~clk;

   multicycle_controller #(.ADD_OP(3'b000)) dut (
      .clk(clk), .reset(reset), .toCU(toCU), .jmpCond(jmpCond),
      .CC(CC), .ZZ(ZZ), .NN(NN),
      .pcEn(pcEn), .selPC(selPC), .selAddress(selAddress), .mr(mr), .mw(mw),
      .wordRegEn(wordRegEn), .LSEn(LSEn), .RSEn(RSEn), .DIEn(DIEn),
      .dataRegEn(dataRegEn), .resultRegEn(resultRegEn),
      .CEn(CEn), .ZEn(ZEn), .NEn(NEn), .selALUsrc(selALUsrc), .enb(enb),
      .selData(selData), .selAddressAC(selAddressAC), .operation(operation),
      .halted(halted)
   );

   typedef struct packed {
      logic       pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn;
      logic       dataRegEn, resultRegEn, CEn, ZEn, NEn, selALUsrc, enb;
      logic [1:0] selData, selAddressAC;
      logic [2:0] operation;
      logic       halted;
   } outs_t;

   int checks = 0;
   int errors = 0;

   // Model state: position within the current instruction, not an FSM encoding.
   int         mStep   = 0;
   logic [3:0] mOp     = 4'd0;
   bit         mHalted = 1'b0;
   logic       mC = 1'b0, mZ = 1'b0, mN = 1'b0;

   function automatic outs_t dutOuts();
      outs_t o;
      o.pcEn = pcEn; o.selPC = selPC; o.selAddress = selAddress; o.mr = mr; o.mw = mw;
      o.wordRegEn = wordRegEn; o.LSEn = LSEn; o.RSEn = RSEn; o.DIEn = DIEn;
      o.dataRegEn = dataRegEn; o.resultRegEn = resultRegEn;
      o.CEn = CEn; o.ZEn = ZEn; o.NEn = NEn; o.selALUsrc = selALUsrc; o.enb = enb;
      o.selData = selData; o.selAddressAC = selAddressAC; o.operation = operation;
      o.halted = halted;
      return o;
   endfunction

   function automatic int instrLen(input logic [3:0] op);
      if (op[3]) return 5;
      case (op[2:0])
         3'd0, 3'd2, 3'd3: return 4;
         3'd1, 3'd4:       return 5;
         default:          return 3;
      endcase
   endfunction

   function automatic bit brTaken();
      case (jmpCond)
         2'b00:   return 1'b1;
         2'b01:   return mZ;
         2'b10:   return mC;
         default: return mN;
      endcase
   endfunction

   // Expected outputs for the current cycle from opcode and cycle index within it.
   function automatic outs_t expOuts();
      outs_t e = '0;
      if (reset) return e;
      if (mHalted) begin
         e.halted = 1'b1;
         return e;
      end
      if (mStep == 0) begin
         e.mr = 1; e.LSEn = 1; e.pcEn = 1;
      end else if (mStep == 1) begin
         // decode cycle is silent
      end else if (mOp[3]) begin
         if (mStep == 2) begin
            e.selAddressAC = 2; e.dataRegEn = 1;
         end else if (mStep == 3) begin
            e.selAddressAC = 1; e.operation = mOp[2:0]; e.resultRegEn = 1;
            e.CEn = 1; e.ZEn = 1; e.NEn = 1;
         end else begin
            e.selData = 1; e.selAddressAC = 1; e.enb = 1;
         end
      end else if (mStep == 2) begin
         e.mr = 1; e.RSEn = 1; e.DIEn = 1; e.pcEn = 1;
      end else if (mStep == 3) begin
         case (mOp[2:0])
            3'd0: begin e.selAddress = 1; e.mr = 1; e.enb = 1; end
            3'd1: e.dataRegEn = 1;
            3'd2: begin e.pcEn = 1; e.selPC = 1; end
            3'd3: begin e.pcEn = brTaken(); e.selPC = brTaken(); end
            default: begin
               e.selAddress = 1; e.mr = 1; e.selALUsrc = 1; e.operation = 3'b000;
               e.resultRegEn = 1; e.CEn = 1; e.ZEn = 1; e.NEn = 1;
            end
         endcase
      end else begin
         if (mOp[2:0] == 3'd1) begin
            e.selAddress = 1; e.mw = 1;
         end else begin
            e.selData = 1; e.enb = 1;
         end
      end
      return e;
   endfunction

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs and compare every output against the model.
   task automatic drive(input logic r, input logic [3:0] t, input logic [1:0] j,
                        input logic c, input logic z, input logic n);
      outs_t e, a;
      reset = r; toCU = t; jmpCond = j; CC = c; ZZ = z; NN = n;
      #1;
      e = expOuts();
      a = dutOuts();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL model step=%0d op=%h halted=%0d act=%h exp=%h at %0t",
                  mStep, mOp, mHalted, a, e, $time);
      end
   endtask

   task automatic adv();
      outs_t e;
      @(posedge clk);
      e = expOuts();
      if (reset) begin
         mStep = 0; mOp = 4'd0; mHalted = 1'b0; mC = 0; mZ = 0; mN = 0;
      end else if (!mHalted) begin
         if (e.CEn) begin mC = CC; mZ = ZZ; mN = NN; end
         if (mStep == 0) mOp = toCU;
         if (mStep == 1 && mOp == 4'b0111) mHalted = 1'b1;
         else begin
            mStep++;
            if (mStep >= instrLen(mOp)) mStep = 0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      outs_t hv;
      int    resetLeft;
      logic  r;
      reset = 1; toCU = 0; jmpCond = 0; CC = 0; ZZ = 0; NN = 0;
      @(negedge clk);

      // Reset hold, then first fetch
      repeat (3) begin
         drive(1, 4'h0, 2'b00, 0, 0, 0);
         lit("reset_zero", dutOuts(), 32'h0);
         adv();
      end
      drive(0, 4'h0, 2'b00, 0, 0, 0);
      lit("fetch1", {mr, LSEn, pcEn, selPC}, 4'b1110);
      adv();

      // LD
      drive(0, 4'h0, 2'b00, 0, 0, 0); lit("ld_decode", dutOuts(), 32'h0); adv();
      drive(0, 4'h0, 2'b00, 0, 0, 0); lit("ld_fetch2", {RSEn, DIEn, pcEn}, 3'b111); adv();
      drive(0, 4'h0, 2'b00, 0, 0, 0);
      lit("ld_exec", {enb, selAddress, mr, selData}, 5'b11100); adv();
      drive(0, 4'hA, 2'b00, 0, 0, 0); lit("ld_next_f1", {mr, LSEn, pcEn}, 3'b111); adv();

      // Register op 1010
      drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
      drive(0, 4'h0, 2'b00, 0, 0, 0); lit("reg_a", {dataRegEn, selAddressAC}, 3'b110); adv();
      drive(0, 4'h0, 2'b00, 1, 0, 1);
      lit("reg_b", {operation, CEn, ZEn, NEn, resultRegEn, selAddressAC}, 9'b010_1111_01); adv();
      drive(0, 4'h0, 2'b00, 0, 0, 0);
      lit("reg_wb", {enb, selData, selAddressAC}, 5'b1_01_01); adv();

      // ADDM setting Z, then BR on Z; repeated with Z clear
      for (int k = 0; k < 2; k++) begin
         logic zv;
         zv = (k == 0);
         drive(0, 4'h4, 2'b00, 0, 0, 0); adv();
         drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
         drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
         drive(0, 4'h0, 2'b00, 0, zv, 0);
         lit("addm1", {selAddress, mr, selALUsrc, operation, ZEn}, 7'b1110001); adv();
         drive(0, 4'h3, 2'b00, 0, 0, 0); lit("addm2", {enb, selData}, 3'b101); adv();
         drive(0, 4'h3, 2'b00, 0, 0, 0); adv();
         drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
         drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
         drive(0, 4'h0, 2'b01, 1, 1, 1);
         if (zv) lit("br_taken", {pcEn, selPC}, 2'b11);
         else    lit("br_not_taken", dutOuts(), 32'h0);
         adv();
      end

      // HALT held until reset
      hv = '0; hv.halted = 1'b1;
      drive(0, 4'h7, 2'b00, 0, 0, 0); adv();
      drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
      for (int k = 0; k < 20; k++) begin
         drive(0, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         lit("halt_hold", dutOuts(), hv);
         adv();
      end
      drive(1, 4'h0, 2'b00, 0, 0, 0); lit("halt_reset", dutOuts(), 32'h0); adv();
      drive(0, 4'h1, 2'b00, 0, 0, 0); lit("post_halt_f1", {halted, mr, LSEn, pcEn}, 4'b0111); adv();

      // STORE interrupted by reset in ST1
      drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
      drive(0, 4'h0, 2'b00, 0, 0, 0); adv();
      drive(1, 4'h0, 2'b00, 0, 0, 0); lit("st1_reset", dutOuts(), 32'h0); adv();
      drive(0, 4'h2, 2'b00, 0, 0, 0); lit("st_abort_f1", {mw, mr, LSEn, pcEn}, 4'b0111); adv();

      // Randomised instruction stream with occasional resets
      resetLeft = 0;
      for (int i = 0; i < 4000; i++) begin
         if (resetLeft == 0) begin
            if (mHalted ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 199) == 0))
               resetLeft = $urandom_range(1, 3);
         end
         r = (resetLeft > 0);
         if (r) resetLeft--;
         drive(r, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         adv();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
